// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit scheduler: FSM encoding, ARP opcodes,
// broadcast address and the queued request record.
package arp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } sched_state_t;

  localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY = 16'h0002;
  localparam logic [47:0] BCAST_MAC    = 48'hffff_ffff_ffff;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_req_t;

  // Gratuitous announcements go out as requests, answers as replies.
  function automatic logic [15:0] arp_opcode(input logic grat);
    return grat ? ARP_OP_REQ : ARP_OP_REPLY;
  endfunction

endpackage

// File: rtl/arp_tx_sched_if.sv
// Request (RX parser side) and frame issue (transmitter side) handshakes of the
// ARP transmit scheduler.
interface arp_tx_sched_if;
  import arp_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_mac;
  logic [31:0] req_ip;
  logic        tx_send;
  logic        tx_grat;
  logic [47:0] tx_dest_mac;
  logic [31:0] tx_dest_ip;
  logic        tx_done;

  modport master (
    input  req_valid, req_mac, req_ip, tx_done,
    output req_ready, tx_send, tx_grat, tx_dest_mac, tx_dest_ip
  );

  modport slave (
    output req_valid, req_mac, req_ip, tx_done,
    input  req_ready, tx_send, tx_grat, tx_dest_mac, tx_dest_ip
  );

endinterface

// File: rtl/arp_req_fifo.sv
// Synchronous request FIFO with combinational head read; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module arp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 80
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/arp_tx_sched.sv
// Sequences ARP replies and periodic gratuitous announcements toward the frame
// transmitter, one frame at a time with a done/timeout wait and an idle gap.
module arp_tx_sched
  import arp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int GRAT_PERIOD = 125000000,
  parameter int MAX_BURST   = 4,
  parameter int GAP_CYCLES  = 12,
  parameter int TX_TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        areset_n,
  arp_tx_sched_if.master              bus,
  input  logic                        grat_en,
  input  logic [31:0]                 my_ip,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic [15:0]                 drop_cnt,
  output logic [7:0]                  tmo_cnt
);

  localparam int CW = $clog2(TX_TIMEOUT > GAP_CYCLES ? TX_TIMEOUT : GAP_CYCLES) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [31:0]   GRAT_LAST = 32'(GRAT_PERIOD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TX_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  sched_state_t  state, state_nxt;
  arp_req_t      head;
  logic          fifo_full, fifo_empty;
  logic          pick_grat, pick_reply, timeout;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   timer;
  logic          grat_pend;
  logic [BW-1:0] burst;
  logic          grat_q;
  logic [47:0]   mac_q;
  logic [31:0]   ip_q;

  arp_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(80)) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (bus.req_valid),
    .pop      (pick_reply),
    .din      ({bus.req_mac, bus.req_ip}),
    .dout     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (pending)
  );

  assign bus.req_ready   = !fifo_full;
  assign bus.tx_send     = (state == ST_SEND);
  assign bus.tx_grat     = grat_q;
  assign bus.tx_dest_mac = mac_q;
  assign bus.tx_dest_ip  = ip_q;

  // A single pending flag: an expiry while one is already pending is absorbed.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      timer     <= '0;
      grat_pend <= 1'b0;
      burst     <= '0;
    end else begin
      if (!grat_en) begin
        timer     <= '0;
        grat_pend <= 1'b0;
      end else begin
        timer <= (timer == GRAT_LAST) ? '0 : timer + 32'd1;
        if (pick_grat)                grat_pend <= 1'b0;
        else if (timer == GRAT_LAST)  grat_pend <= 1'b1;
      end
      if (!grat_pend || pick_grat)               burst <= '0;
      else if (pick_reply && burst != BURST_MAX) burst <= burst + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pick_grat  = 1'b0;
    pick_reply = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grat_pend && (fifo_empty || burst == BURST_MAX)) begin
          pick_grat = 1'b1;
          state_nxt = ST_SEND;
        end else if (!fifo_empty) begin
          pick_reply = 1'b1;
          state_nxt  = ST_SEND;
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Destination registers hold from the pick until the next pick.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      grat_q   <= 1'b0;
      mac_q    <= '0;
      ip_q     <= '0;
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pick_grat) begin
        grat_q <= 1'b1;
        mac_q  <= BCAST_MAC;
        ip_q   <= my_ip;
      end else if (pick_reply) begin
        grat_q <= 1'b0;
        mac_q  <= head.mac;
        ip_q   <= head.ip;
      end
      if (timeout && tmo_cnt != '1)                       tmo_cnt  <= tmo_cnt + 8'd1;
      if (bus.req_valid && fifo_full && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_arp_tx_sched.sv
// Directed bench for arp_tx_sched: expected frames are queued as stimulus is
// driven and compared whenever the scheduler raises tx_send.
module tb_arp_tx_sched;
  import arp_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int GRAT_PERIOD = 64;
  localparam int MAX_BURST   = 4;
  localparam int GAP_CYCLES  = 12;
  localparam int TX_TIMEOUT  = 4096;

  typedef struct packed {
    logic        grat;
    logic [47:0] mac;
    logic [31:0] ip;
  } frame_t;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        grat_en = 1'b0;
  logic [31:0] my_ip = 32'h0a00_0001;
  logic [2:0]  pending;
  logic [15:0] drop_cnt;
  logic [7:0]  tmo_cnt;

  frame_t sb[$];
  int     passed = 0;
  int     failed = 0;
  int     total  = 0;
  int     cyc    = 0;
  int     last_send = 0;

  arp_tx_sched_if bus();

  arp_tx_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .GRAT_PERIOD (GRAT_PERIOD),
    .MAX_BURST   (MAX_BURST),
    .GAP_CYCLES  (GAP_CYCLES),
    .TX_TIMEOUT  (TX_TIMEOUT)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus),
    .grat_en  (grat_en),
    .my_ip    (my_ip),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .tmo_cnt  (tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request that the bench expects to be accepted this cycle.
  task automatic apply_stimulus(input logic [47:0] mac, input logic [31:0] ip);
    check_output("req_ready", 81'(bus.req_ready), 81'(1));
    bus.req_valid = 1'b1;
    bus.req_mac   = mac;
    bus.req_ip    = ip;
    sb.push_back({1'b0, mac, ip});
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_send(input int bound, output bit found, output int waited);
    frame_t obs;
    frame_t exp;
    found  = 1'b0;
    waited = 0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (bus.tx_send) begin
        found  = 1'b1;
        waited = i;
        break;
      end
    end
    if (found) begin
      last_send = cyc;
      check_output("sb_nonempty", 81'(sb.size() != 0), 81'(1));
      if (sb.size() != 0) begin
        obs = {bus.tx_grat, bus.tx_dest_mac, bus.tx_dest_ip};
        exp = sb.pop_front();
        check_output("frame", obs, exp);
      end
    end
  endtask

  task automatic expect_send(input string tag, input int bound, input int exp_wait);
    bit found;
    int waited;
    wait_send(bound, found, waited);
    check_output({tag, "_seen"}, 81'(found), 81'(1));
    if (exp_wait >= 0) check_output({tag, "_latency"}, 81'(waited), 81'(exp_wait));
  endtask

  task automatic give_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  // Called in the SEND cycle: checks the pulse ends, then finishes the frame.
  task automatic complete_frame();
    tick();
    check_output("send_pulse", 81'(bus.tx_send), 81'(0));
    give_done();
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_pending"}, 81'(pending), 81'(0));
    check_output({tag, "_ready"}, 81'(bus.req_ready), 81'(1));
    check_output({tag, "_send"}, 81'(bus.tx_send), 81'(0));
    check_output({tag, "_dest"}, {bus.tx_grat, bus.tx_dest_mac, bus.tx_dest_ip}, 81'(0));
    check_output({tag, "_drop"}, 81'(drop_cnt), 81'(0));
    check_output({tag, "_tmo"}, 81'(tmo_cnt), 81'(0));
  endtask

  initial begin
    bit found;
    int waited;
    int model_cnt;
    int t_first;
    logic exp_ready;

    bus.req_valid = 1'b0;
    bus.req_mac   = '0;
    bus.req_ip    = '0;
    bus.tx_done   = 1'b0;

    repeat (3) tick();
    check_reset_state("reset");
    areset_n = 1'b1;
    tick();

    // Single reply: two-cycle latency, then the post-frame gap.
    $display("[TB] single reply and gap");
    apply_stimulus(48'h0a0b_0c0d_0e0f, 32'hc0a8_0105);
    check_output("t1_early_send", 81'(bus.tx_send), 81'(0));
    check_output("t1_pending", 81'(pending), 81'(1));
    expect_send("t1", 5, 1);
    tick();
    check_output("send_pulse", 81'(bus.tx_send), 81'(0));
    bus.req_valid = 1'b1;
    bus.req_mac   = 48'h0011_2233_4455;
    bus.req_ip    = 32'hc0a8_0106;
    sb.push_back({1'b0, 48'h0011_2233_4455, 32'hc0a8_0106});
    bus.tx_done   = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.tx_done   = 1'b0;
    expect_send("t1_gap", 40, GAP_CYCLES + 1);
    complete_frame();
    repeat (GAP_CYCLES + 2) tick();

    // Fill the queue while a frame is outstanding; fifth request stalls.
    $display("[TB] queue full and drop count");
    apply_stimulus(48'h1000_0000_0000, 32'h0a01_0000);
    expect_send("t2_a", 5, 1);
    tick();
    model_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      exp_ready = (model_cnt < FIFO_DEPTH);
      check_output("t2_ready", 81'(bus.req_ready), 81'(exp_ready));
      bus.req_valid = 1'b1;
      bus.req_mac   = 48'h1000_0000_0001 + 48'(k);
      bus.req_ip    = 32'h0a01_0001 + 32'(k);
      if (exp_ready) begin
        sb.push_back({1'b0, bus.req_mac, bus.req_ip});
        model_cnt++;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check_output("t2_drop", 81'(drop_cnt), 81'(1));
    check_output("t2_pending", 81'(pending), 81'(FIFO_DEPTH));
    tick();
    check_output("t2_drop_hold", 81'(drop_cnt), 81'(1));
    give_done();
    for (int k = 0; k < 4; k++) begin
      expect_send("t2_order", 40, -1);
      complete_frame();
    end
    repeat (GAP_CYCLES + 2) tick();
    check_output("t2_drained", 81'(pending), 81'(0));

    // Periodic gratuitous announcements with no replies queued.
    $display("[TB] gratuitous period");
    grat_en = 1'b1;
    sb.push_back({1'b1, BCAST_MAC, my_ip});
    expect_send("t3_first", 100, GRAT_PERIOD + 1);
    t_first = last_send;
    my_ip = 32'h0a00_0002;
    sb.push_back({1'b1, BCAST_MAC, 32'h0a00_0002});
    complete_frame();
    expect_send("t3_second", 100, -1);
    check_output("t3_period", 81'(last_send - t_first), 81'(GRAT_PERIOD));
    complete_frame();
    grat_en = 1'b0;
    wait_send(200, found, waited);
    check_output("t3_quiet", 81'(found), 81'(0));

    // Full queue with an announcement pending: MAX_BURST replies, then grat.
    $display("[TB] burst limit");
    apply_stimulus(48'h2000_0000_0000, 32'h0a02_0000);
    expect_send("t4_r0", 5, 1);
    for (int k = 1; k <= 4; k++) apply_stimulus(48'h2000_0000_0000 + 48'(k), 32'h0a02_0000 + 32'(k));
    check_output("t4_full", 81'(pending), 81'(FIFO_DEPTH));
    grat_en = 1'b1;
    repeat (GRAT_PERIOD + 8) tick();
    give_done();
    for (int j = 1; j <= MAX_BURST; j++) begin
      expect_send("t4_burst", 40, -1);
      if (j == 1) sb.push_back({1'b1, BCAST_MAC, my_ip});
      apply_stimulus(48'h2000_0000_0004 + 48'(j), 32'h0a02_0004 + 32'(j));
      give_done();
    end
    expect_send("t4_grat", 40, -1);
    complete_frame();
    grat_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      expect_send("t4_drain", 40, -1);
      complete_frame();
    end
    repeat (GAP_CYCLES + 2) tick();
    check_output("t4_drained", 81'(pending), 81'(0));

    // Transmitter never answers: timeout, then the next frame goes out.
    $display("[TB] done timeout");
    apply_stimulus(48'h3000_0000_0001, 32'h0a03_0001);
    expect_send("t5_t1", 5, 1);
    t_first = last_send;
    apply_stimulus(48'h3000_0000_0002, 32'h0a03_0002);
    repeat (4000) tick();
    check_output("t5_tmo_early", 81'(tmo_cnt), 81'(0));
    expect_send("t5_t2", 300, -1);
    check_output("t5_latency", 81'(last_send - t_first), 81'(TX_TIMEOUT + GAP_CYCLES + 2));
    check_output("t5_tmo", 81'(tmo_cnt), 81'(1));
    complete_frame();
    repeat (GAP_CYCLES + 2) tick();

    // Asynchronous reset while waiting with three requests queued.
    $display("[TB] reset mid-frame");
    apply_stimulus(48'h4000_0000_0001, 32'h0a04_0001);
    expect_send("t6_q1", 5, 1);
    for (int k = 2; k <= 4; k++) apply_stimulus(48'h4000_0000_0000 + 48'(k), 32'h0a04_0000 + 32'(k));
    check_output("t6_pending", 81'(pending), 81'(3));
    #2;
    areset_n = 1'b0;
    #1;
    check_reset_state("t6_reset");
    sb.delete();
    tick();
    areset_n = 1'b1;
    tick();
    give_done();
    wait_send(40, found, waited);
    check_output("t6_quiet", 81'(found), 81'(0));
    check_output("t6_pending_after", 81'(pending), 81'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
